// File: rtl/bus_cycle_pkg.sv
// Shared definitions for the 8085 bus-cycle engine: T-state encodings, cycle-type codes
// and strobe defaults used by the engine and by the core control block.
package bus_cycle_pkg;

    // State encoding doubles as the externally visible tstate value.
    typedef enum logic [3:0] {
        StIdle = 4'b0000,
        StT1   = 4'b0001,
        StT2   = 4'b0010,
        StT3   = 4'b0011,
        StTh   = 4'b0111,
        StTw   = 4'b1000
    } tstate_e;

    localparam logic [2:0] STAT_OF   = 3'b011;
    localparam logic [2:0] STAT_MR   = 3'b010;
    localparam logic [2:0] STAT_MW   = 3'b001;
    localparam logic [2:0] STAT_DR   = 3'b110;
    localparam logic [2:0] STAT_DW   = 3'b101;
    localparam logic [2:0] STAT_INTA = 3'b111;

    typedef enum logic [1:0] {
        CycNone,
        CycRead,
        CycWrite,
        CycInta
    } cyc_e;

    typedef enum logic [1:0] {
        AdHold,
        AdAddr,
        AdData
    } ad_sel_e;

    typedef struct packed {
        logic    rd_;
        logic    wr_;
        logic    inta_;
        logic    ad_oe;
        ad_sel_e ad_sel;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{
        rd_:    1'b1,
        wr_:    1'b1,
        inta_:  1'b1,
        ad_oe:  1'b0,
        ad_sel: AdHold
    };

    // Unlisted codes (000, 100) run as bus-idle cycles.
    function automatic cyc_e cyc_kind(input logic [2:0] stat);
        cyc_e kind;
        case (stat)
            STAT_OF, STAT_MR, STAT_DR: kind = CycRead;
            STAT_MW, STAT_DW:          kind = CycWrite;
            STAT_INTA:                 kind = CycInta;
            default:                   kind = CycNone;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/bus_cycle_if.sv
// Control-side handshake plus pin-side bus signals of the bus-cycle engine.
interface bus_cycle_if #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 16
) ();

    logic                         req;
    logic [2:0]                   stat;
    logic [ADDRSIZE-1:0]          addr;
    logic [DATASIZE-1:0]          wdata;
    logic                         ready;
    logic                         hold;
    logic [DATASIZE-1:0]          ad_in;

    logic                         ack;
    logic                         busy;
    logic                         done;
    logic [DATASIZE-1:0]          rdata;
    logic [3:0]                   tstate;
    logic                         ale;
    logic                         rd_;
    logic                         wr_;
    logic                         inta_;
    logic                         iom_;
    logic                         s1;
    logic                         s0;
    logic                         busz;
    logic [ADDRSIZE-DATASIZE-1:0] a_hi;
    logic [DATASIZE-1:0]          ad_out;
    logic                         ad_oe;
    logic                         hlda;

    modport slave (
        input  req, stat, addr, wdata, ready, hold, ad_in,
        output ack, busy, done, rdata, tstate, ale, rd_, wr_, inta_, iom_, s1, s0,
               busz, a_hi, ad_out, ad_oe, hlda
    );

    modport master (
        output req, stat, addr, wdata, ready, hold, ad_in,
        input  ack, busy, done, rdata, tstate, ale, rd_, wr_, inta_, iom_, s1, s0,
               busz, a_hi, ad_out, ad_oe, hlda
    );

endinterface

// File: rtl/bus_strobe_dec.sv
// Combinational map from {cycle type, bus phase} to the read/write/inta strobes,
// the AD output enable and the AD drive-value select.
module bus_strobe_dec
    import bus_cycle_pkg::*;
(
    input  logic [2:0] stat,
    input  tstate_e    phase,
    output strobe_t    strb
);

    always_comb begin
        strb = STROBE_IDLE;
        case (phase)
            StT1: begin
                strb.ad_oe  = 1'b1;
                strb.ad_sel = AdAddr;
            end
            StT2, StTw, StT3: begin
                case (cyc_kind(stat))
                    CycRead:  strb.rd_ = 1'b0;
                    CycWrite: begin
                        strb.wr_    = 1'b0;
                        strb.ad_oe  = 1'b1;
                        strb.ad_sel = AdData;
                    end
                    CycInta:  strb.inta_ = 1'b0;
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_cycle.sv
// 8085 machine-cycle bus engine: sequences T1/T2/TW/T3/TH for one requested bus cycle,
// with every output registered from the next-state decode.
module bus_cycle
    import bus_cycle_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 16
) (
    input  logic      clk,
    input  logic      rst,
    bus_cycle_if.slave bus
);

    tstate_e             state_q, state_d;
    logic                load;
    logic [2:0]          stat_q, stat_nx;
    logic [ADDRSIZE-1:0] addr_q, addr_nx;
    logic [DATASIZE-1:0] wdata_q, wdata_nx;
    strobe_t             strb;
    logic                busy_d;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.hold) begin
                    state_d = StTh;
                end else if (bus.req) begin
                    state_d = StT1;
                    load    = 1'b1;
                end
            end
            StT1: state_d = StT2;
            StT2: begin
                // Bus-idle cycles ignore READY and never insert waits.
                if (bus.ready || cyc_kind(stat_q) == CycNone) state_d = StT3;
                else                                          state_d = StTw;
            end
            StTw: if (bus.ready) state_d = StT3;
            StT3: begin
                if (bus.hold) begin
                    state_d = StTh;
                end else if (bus.req) begin
                    state_d = StT1;
                    load    = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StTh: begin
                if (!bus.hold) begin
                    if (bus.req) begin
                        state_d = StT1;
                        load    = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign stat_nx  = load ? bus.stat  : stat_q;
    assign addr_nx  = load ? bus.addr  : addr_q;
    assign wdata_nx = load ? bus.wdata : wdata_q;
    assign busy_d   = (state_d == StT1) || (state_d == StT2) ||
                      (state_d == StTw) || (state_d == StT3);

    bus_strobe_dec u_dec (
        .stat  (stat_nx),
        .phase (state_d),
        .strb  (strb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            stat_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            bus.ack    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.rdata  <= '0;
            bus.ale    <= 1'b0;
            bus.rd_    <= 1'b1;
            bus.wr_    <= 1'b1;
            bus.inta_  <= 1'b1;
            bus.iom_   <= 1'b0;
            bus.s1     <= 1'b1;
            bus.s0     <= 1'b1;
            bus.busz   <= 1'b1;
            bus.a_hi   <= '0;
            bus.ad_out <= '0;
            bus.ad_oe  <= 1'b0;
            bus.hlda   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_nx;
            addr_q    <= addr_nx;
            wdata_q   <= wdata_nx;
            bus.ack   <= (state_d == StT1);
            bus.busy  <= busy_d;
            bus.done  <= (state_q == StT3);
            bus.ale   <= (state_d == StT1);
            bus.rd_   <= strb.rd_;
            bus.wr_   <= strb.wr_;
            bus.inta_ <= strb.inta_;
            bus.ad_oe <= strb.ad_oe;
            bus.busz  <= !busy_d;
            bus.hlda  <= (state_d == StTh);
            if (state_q == StT3 &&
                (cyc_kind(stat_q) == CycRead || cyc_kind(stat_q) == CycInta)) begin
                bus.rdata <= bus.ad_in;
            end
            case (strb.ad_sel)
                AdAddr:  bus.ad_out <= addr_nx[DATASIZE-1:0];
                AdData:  bus.ad_out <= wdata_nx;
                default: ;
            endcase
            // Status and A15-8 change only at T1 and otherwise hold their last values.
            if (state_d == StT1) begin
                bus.a_hi                     <= addr_nx[ADDRSIZE-1:DATASIZE];
                {bus.iom_, bus.s1, bus.s0}   <= stat_nx;
            end
        end
    end

    assign bus.tstate = state_q;

endmodule

// File: tb/tb_bus_cycle.sv
// Directed self-checking bench for bus_cycle with hand-computed expected values.
module tb_bus_cycle;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bus_cycle_if #(.DATASIZE(8), .ADDRSIZE(16)) bus ();

    bus_cycle #(.DATASIZE(8), .ADDRSIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {ale, rd_, wr_, inta_, ad_oe, busz, ack, done, busy, hlda}
    function automatic logic [31:0] pins();
        return 32'({bus.ale, bus.rd_, bus.wr_, bus.inta_, bus.ad_oe, bus.busz,
                    bus.ack, bus.done, bus.busy, bus.hlda});
    endfunction

    function automatic logic [31:0] st3();
        return 32'({bus.iom_, bus.s1, bus.s0});
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_ts"},    32'(bus.tstate), 0);
        check({tag, "_pins"},  pins(), 'b0_111_0_1_0000);
        check({tag, "_stat"},  st3(), 'b011);
        check({tag, "_ad"},    32'(bus.ad_out), 0);
        check({tag, "_ahi"},   32'(bus.a_hi), 0);
        check({tag, "_rdata"}, 32'(bus.rdata), 0);
    endtask

    initial begin
        bus.req = 0; bus.stat = 0; bus.addr = 0; bus.wdata = 0;
        bus.ready = 1; bus.hold = 0; bus.ad_in = 0;
        #12;
        check_reset("rst");
        rst = 1'b1;
        step();
        check("idle_ts", 32'(bus.tstate), 0);

        // MR 0x1234, ready=1
        bus.req = 1; bus.stat = 3'b010; bus.addr = 16'h1234; bus.ad_in = 8'h5A;
        step();
        check("mr_t1_ts",   32'(bus.tstate), 1);
        check("mr_t1_pins", pins(), 'b1_111_1_0_1010);
        check("mr_t1_ad",   32'(bus.ad_out), 'h34);
        check("mr_t1_ahi",  32'(bus.a_hi), 'h12);
        check("mr_t1_stat", st3(), 'b010);
        bus.req = 0;
        step();
        check("mr_t2_ts",   32'(bus.tstate), 2);
        check("mr_t2_pins", pins(), 'b0_011_0_0_0010);
        step();
        check("mr_t3_ts",   32'(bus.tstate), 3);
        check("mr_t3_pins", pins(), 'b0_011_0_0_0010);
        step();
        check("mr_end_ts",    32'(bus.tstate), 0);
        check("mr_end_pins",  pins(), 'b0_111_0_1_0100);
        check("mr_end_rdata", 32'(bus.rdata), 'h5A);
        step();
        check("mr_done_drop", 32'(bus.done), 0);

        // MW 0x8000 / 0xC3 with two wait states
        bus.req = 1; bus.stat = 3'b001; bus.addr = 16'h8000; bus.wdata = 8'hC3;
        bus.ready = 0; bus.ad_in = 8'h77;
        step();
        check("mw_t1_ts",  32'(bus.tstate), 1);
        check("mw_t1_ad",  32'(bus.ad_out), 'h00);
        check("mw_t1_ahi", 32'(bus.a_hi), 'h80);
        bus.req = 0;
        step();
        check("mw_t2_ts",   32'(bus.tstate), 2);
        check("mw_t2_pins", pins(), 'b0_101_1_0_0010);
        check("mw_t2_ad",   32'(bus.ad_out), 'hC3);
        step();
        check("mw_tw1_ts",   32'(bus.tstate), 8);
        check("mw_tw1_pins", pins(), 'b0_101_1_0_0010);
        step();
        check("mw_tw2_ts",   32'(bus.tstate), 8);
        check("mw_tw2_ad",   32'(bus.ad_out), 'hC3);
        bus.ready = 1;
        step();
        check("mw_t3_ts",   32'(bus.tstate), 3);
        check("mw_t3_pins", pins(), 'b0_101_1_0_0010);
        step();
        check("mw_end_pins",  pins(), 'b0_111_0_1_0100);
        check("mw_end_rdata", 32'(bus.rdata), 'h5A);

        // INTA then back-to-back OF with req held
        bus.req = 1; bus.stat = 3'b111; bus.addr = 16'h0000; bus.ad_in = 8'hFF;
        step();
        check("inta_t1_ts", 32'(bus.tstate), 1);
        bus.stat = 3'b011; bus.addr = 16'h0040;
        step();
        check("inta_t2_pins", pins(), 'b0_110_0_0_0010);
        step();
        check("inta_t3_pins", pins(), 'b0_110_0_0_0010);
        step();
        check("of_t1_ts",    32'(bus.tstate), 1);
        check("of_t1_pins",  pins(), 'b1_111_1_0_1110);
        check("of_t1_rdata", 32'(bus.rdata), 'hFF);
        check("of_t1_stat",  st3(), 'b011);
        check("of_t1_ad",    32'(bus.ad_out), 'h40);
        bus.req = 0; bus.ad_in = 8'h3C;
        step();
        check("of_t2_pins", pins(), 'b0_011_0_0_0010);
        step();
        step();
        check("of_end_rdata", 32'(bus.rdata), 'h3C);
        check("of_end_done",  32'(bus.done), 1);

        // hold raised during T2 of a DR
        bus.req = 1; bus.stat = 3'b110; bus.addr = 16'h2000; bus.ad_in = 8'h99;
        step();
        bus.req = 0;
        step();
        check("dr_t2_ts", 32'(bus.tstate), 2);
        bus.hold = 1;
        step();
        check("dr_t3_ts",   32'(bus.tstate), 3);
        check("dr_t3_hlda", 32'(bus.hlda), 0);
        step();
        check("dr_th_ts",    32'(bus.tstate), 7);
        check("dr_th_pins",  pins(), 'b0_111_0_1_0101);
        check("dr_th_rdata", 32'(bus.rdata), 'h99);
        check("dr_th_stat",  32'({bus.s1, bus.s0}), 'b10);
        step();
        check("dr_th2_ts", 32'(bus.tstate), 7);
        bus.hold = 0;
        step();
        check("dr_rel_ts",   32'(bus.tstate), 0);
        check("dr_rel_hlda", 32'(bus.hlda), 0);

        // hold taken from IDLE
        bus.hold = 1;
        step();
        check("idle_th_ts",   32'(bus.tstate), 7);
        check("idle_th_hlda", 32'(bus.hlda), 1);
        bus.hold = 0;
        step();
        check("idle_th_rel", 32'(bus.tstate), 0);

        // reset asserted during TW
        bus.req = 1; bus.stat = 3'b010; bus.addr = 16'h4321; bus.ready = 0;
        step();
        bus.req = 0;
        step();
        step();
        check("rtw_ts", 32'(bus.tstate), 8);
        #2 rst = 1'b0;
        #1;
        check_reset("rtw");
        bus.req = 1; bus.stat = 3'b010; bus.ready = 1; bus.ad_in = 8'h11;
        #1 rst = 1'b1;
        step();
        check("rtw_t1_ts",   32'(bus.tstate), 1);
        check("rtw_t1_done", 32'(bus.done), 0);
        bus.req = 0;
        step();
        step();
        step();
        check("rtw_end_rdata", 32'(bus.rdata), 'h11);
        check("rtw_end_done",  32'(bus.done), 1);

        // unlisted stat=000 runs as bus-idle cycle, ignores ready
        bus.req = 1; bus.stat = 3'b000; bus.addr = 16'h00AB; bus.ready = 0; bus.ad_in = 8'hEE;
        step();
        check("nop_t1_pins", pins(), 'b1_111_1_0_1010);
        check("nop_t1_stat", st3(), 'b000);
        bus.req = 0;
        step();
        check("nop_t2_ts",   32'(bus.tstate), 2);
        check("nop_t2_pins", pins(), 'b0_111_0_0_0010);
        step();
        check("nop_t3_ts", 32'(bus.tstate), 3);
        step();
        check("nop_end_pins",  pins(), 'b0_111_0_1_0100);
        check("nop_end_rdata", 32'(bus.rdata), 'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
